// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Multi-cycle control unit for the MIPS-31 datapath. Decodes op/funct
//   once per instruction and sequences FETCH, DECODE, EXEC, MEM and WB.
//   Waits for instruction and data memories that may stall. Flags
//   undecodable instructions and memory timeouts.
//
// Parameters
//   TIMEOUT  maximum wait cycles on imem_ready/dmem_ready (0 = no timeout)
//   RET_W    width of the retired-instruction counter
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   op, funct           instruction fields from IR
//   Z                   ALU zero flag (sampled in EXEC)
//   imem_ready          instruction word valid this cycle
//   dmem_ready          data access completes this cycle
//   imem_req, ir_W      fetch request, IR load strobe
//   pc_W, pc_src        PC write enable and next-PC select
//   dmem_R, dmem_W      data memory read/write
//   reg_W, reg_dst      regfile write enable, destination select
//   wb_src              write-back source select
//   alu_a_sa, alu_b_imm ALU operand selects
//   ext                 one-hot extender select
//   aluc                ALU operation
//   state               current FSM state (debug)
//   illegal             one-cycle pulse on an undecodable instruction
//   fault               sticky memory-timeout flag
//   retired             retired legal instruction count
module multicycle_controller #(
  parameter int TIMEOUT = 16,
  parameter int RET_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             Z,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_W,
  output logic             pc_W,
  output logic [1:0]       pc_src,
  output logic             dmem_R,
  output logic             dmem_W,
  output logic             reg_W,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wb_src,
  output logic             alu_a_sa,
  output logic             alu_b_imm,
  output logic [4:0]       ext,
  output logic [3:0]       aluc,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             fault,
  output logic [RET_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_RALU, C_SHIFT, C_IALU, C_LUI, C_LW, C_SW,
    C_BEQ, C_BNE, C_J, C_JAL, C_JR, C_ILL
  } cls_t;

  typedef struct packed {
    cls_t       cls;
    logic [3:0] aluc;
    logic [4:0] ext;
    logic       a_sa;
    logic       b_imm;
  } dec_t;

  localparam logic [4:0] EXT1   = 5'b00001;
  localparam logic [4:0] EXT5   = 5'b00010;
  localparam logic [4:0] EXT16  = 5'b00100;
  localparam logic [4:0] SEXT16 = 5'b01000;
  localparam logic [4:0] SEXT18 = 5'b10000;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  // slti/sltiu use two extenders at once: S_Ext16 on the immediate and
  // Ext1 on the compare result, so ext carries both bits for them.
  function automatic dec_t decode(input logic [5:0] op_i, input logic [5:0] fn_i);
    dec_t d;
    d.cls   = C_ILL;
    d.aluc  = 4'b0000;
    d.ext   = 5'b00000;
    d.a_sa  = 1'b0;
    d.b_imm = 1'b0;
    if (op_i == 6'h00) begin
      d.cls = C_RALU;
      case (fn_i)
        6'h20: d.aluc = 4'b0010;
        6'h21: d.aluc = 4'b0000;
        6'h22: d.aluc = 4'b0011;
        6'h23: d.aluc = 4'b0001;
        6'h24: d.aluc = 4'b0100;
        6'h25: d.aluc = 4'b0101;
        6'h26: d.aluc = 4'b0110;
        6'h27: d.aluc = 4'b0111;
        6'h2A: begin d.aluc = 4'b1011; d.ext = EXT1; end
        6'h2B: begin d.aluc = 4'b1010; d.ext = EXT1; end
        6'h00: begin d.cls = C_SHIFT; d.aluc = 4'b1110; d.ext = EXT5; d.a_sa = 1'b1; end
        6'h02: begin d.cls = C_SHIFT; d.aluc = 4'b1101; d.ext = EXT5; d.a_sa = 1'b1; end
        6'h03: begin d.cls = C_SHIFT; d.aluc = 4'b1100; d.ext = EXT5; d.a_sa = 1'b1; end
        6'h04: begin d.cls = C_SHIFT; d.aluc = 4'b1110; end
        6'h06: begin d.cls = C_SHIFT; d.aluc = 4'b1101; end
        6'h07: begin d.cls = C_SHIFT; d.aluc = 4'b1100; end
        6'h08: d.cls = C_JR;
        default: d.cls = C_ILL;
      endcase
    end else begin
      d.b_imm = 1'b1;
      case (op_i)
        6'h08: begin d.cls = C_IALU; d.aluc = 4'b0010; d.ext = SEXT16; end
        6'h09: begin d.cls = C_IALU; d.aluc = 4'b0000; d.ext = SEXT16; end
        6'h0A: begin d.cls = C_IALU; d.aluc = 4'b1011; d.ext = SEXT16 | EXT1; end
        6'h0B: begin d.cls = C_IALU; d.aluc = 4'b1010; d.ext = SEXT16 | EXT1; end
        6'h0C: begin d.cls = C_IALU; d.aluc = 4'b0100; d.ext = EXT16; end
        6'h0D: begin d.cls = C_IALU; d.aluc = 4'b0101; d.ext = EXT16; end
        6'h0E: begin d.cls = C_IALU; d.aluc = 4'b0110; d.ext = EXT16; end
        6'h0F: begin d.cls = C_LUI;  d.aluc = 4'b1000; d.ext = EXT16; end
        6'h23: begin d.cls = C_LW;   d.aluc = 4'b0000; d.ext = SEXT16; end
        6'h2B: begin d.cls = C_SW;   d.aluc = 4'b0000; d.ext = SEXT16; end
        6'h04: begin d.cls = C_BEQ;  d.aluc = 4'b0001; d.ext = SEXT18; d.b_imm = 1'b0; end
        6'h05: begin d.cls = C_BNE;  d.aluc = 4'b0001; d.ext = SEXT18; d.b_imm = 1'b0; end
        6'h02: begin d.cls = C_J;    d.b_imm = 1'b0; end
        6'h03: begin d.cls = C_JAL;  d.b_imm = 1'b0; end
        default: begin d.cls = C_ILL; d.b_imm = 1'b0; end
      endcase
    end
    return d;
  endfunction

  state_t           state_q, state_d;
  dec_t             dec_now, dec_q;
  logic [CNT_W-1:0] wait_q;
  logic [RET_W-1:0] retired_q;
  logic             wait_hit;

  assign dec_now  = decode(op, funct);
  assign wait_hit = (TIMEOUT > 0) && (wait_q == TO_LAST);
  assign state    = state_q;
  assign retired  = retired_q;
  assign fault    = ~rst & (state_q == S_FAULT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      dec_q     <= '0;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) dec_q <= dec_now;
      // Counts cycles spent waiting in one state; any transition restarts it.
      if (state_d != state_q)
        wait_q <= '0;
      else if ((state_q == S_FETCH && !imem_ready) || (state_q == S_MEM && !dmem_ready))
        wait_q <= wait_q + 1'b1;
      if (pc_W && !illegal) retired_q <= retired_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    imem_req  = 1'b0;
    ir_W      = 1'b0;
    pc_W      = 1'b0;
    pc_src    = 2'b00;
    dmem_R    = 1'b0;
    dmem_W    = 1'b0;
    reg_W     = 1'b0;
    reg_dst   = 2'b00;
    wb_src    = 2'b00;
    alu_a_sa  = 1'b0;
    alu_b_imm = 1'b0;
    ext       = 5'b00000;
    aluc      = 4'b0000;
    illegal   = 1'b0;
    // Every output stays low while reset is held, including imem_req.
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_W    = 1'b1;
            state_d = S_DECODE;
          end else if (wait_hit) begin
            state_d = S_FAULT;
          end
        end
        S_DECODE: begin
          if (dec_now.cls == C_ILL) begin
            illegal = 1'b1;
            pc_W    = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          aluc      = dec_q.aluc;
          ext       = dec_q.ext;
          alu_a_sa  = dec_q.a_sa;
          alu_b_imm = dec_q.b_imm;
          case (dec_q.cls)
            C_LW, C_SW: state_d = S_MEM;
            C_BEQ, C_BNE: begin
              pc_W    = 1'b1;
              pc_src  = (((dec_q.cls == C_BEQ) && Z) || ((dec_q.cls == C_BNE) && !Z)) ? 2'b01 : 2'b00;
              state_d = S_FETCH;
            end
            C_J: begin
              pc_W    = 1'b1;
              pc_src  = 2'b10;
              state_d = S_FETCH;
            end
            C_JAL: begin
              pc_W    = 1'b1;
              pc_src  = 2'b10;
              reg_W   = 1'b1;
              reg_dst = 2'b10;
              wb_src  = 2'b10;
              state_d = S_FETCH;
            end
            C_JR: begin
              pc_W    = 1'b1;
              pc_src  = 2'b11;
              state_d = S_FETCH;
            end
            default: state_d = S_WB;
          endcase
        end
        S_MEM: begin
          if (dec_q.cls == C_LW) dmem_R = 1'b1;
          else                   dmem_W = 1'b1;
          if (dmem_ready) begin
            if (dec_q.cls == C_LW) begin
              state_d = S_WB;
            end else begin
              pc_W    = 1'b1;
              state_d = S_FETCH;
            end
          end else if (wait_hit) begin
            state_d = S_FAULT;
          end
        end
        S_WB: begin
          reg_W   = 1'b1;
          pc_W    = 1'b1;
          reg_dst = ((dec_q.cls == C_RALU) || (dec_q.cls == C_SHIFT)) ? 2'b00 : 2'b01;
          wb_src  = (dec_q.cls == C_LW) ? 2'b01 : 2'b00;
          state_d = S_FETCH;
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  op, funct;
  logic        Z, imem_ready, dmem_ready;
  logic        imem_req, ir_W, pc_W, dmem_R, dmem_W, reg_W;
  logic [1:0]  pc_src, reg_dst, wb_src;
  logic        alu_a_sa, alu_b_imm;
  logic [4:0]  ext;
  logic [3:0]  aluc;
  logic [2:0]  state;
  logic        illegal, fault;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.TIMEOUT(16), .RET_W(32)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .Z(Z),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_W(ir_W), .pc_W(pc_W), .pc_src(pc_src),
    .dmem_R(dmem_R), .dmem_W(dmem_W), .reg_W(reg_W), .reg_dst(reg_dst),
    .wb_src(wb_src), .alu_a_sa(alu_a_sa), .alu_b_imm(alu_b_imm),
    .ext(ext), .aluc(aluc), .state(state), .illegal(illegal),
    .fault(fault), .retired(retired)
  );

  // Advance one clock; sampling happens 1 time unit after the falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; Z = 1'b0; op = 6'h00; funct = 6'h00;
    tick();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_state got %0h exp 0", state); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_imem_req got %0h exp 0", imem_req); end
    checks++; if (ir_W !== 1'b0 || pc_W !== 1'b0) begin errors++; $display("FAIL rst_enables got ir_W=%0h pc_W=%0h exp 0 0", ir_W, pc_W); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %0h exp 0", fault); end
    checks++; if (retired !== 32'd0) begin errors++; $display("FAIL rst_retired got %0h exp 0", retired); end
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL fetch_req got %0h exp 1", imem_req); end
  endtask

  task automatic test_addu();
    op = 6'h00; funct = 6'h21;
    #1;
    checks++; if (state !== 3'd0 || ir_W !== 1'b1) begin errors++; $display("FAIL addu_fetch got state=%0h ir_W=%0h exp 0 1", state, ir_W); end
    tick();
    checks++; if (state !== 3'd1 || illegal !== 1'b0 || reg_W !== 1'b0) begin errors++; $display("FAIL addu_decode got state=%0h illegal=%0h reg_W=%0h exp 1 0 0", state, illegal, reg_W); end
    tick();
    checks++; if (state !== 3'd2 || aluc !== 4'b0000 || reg_W !== 1'b0) begin errors++; $display("FAIL addu_exec got state=%0h aluc=%0h reg_W=%0h exp 2 0 0", state, aluc, reg_W); end
    tick();
    checks++; if (state !== 3'd4 || reg_W !== 1'b1 || reg_dst !== 2'b00 || wb_src !== 2'b00 || pc_W !== 1'b1)
      begin errors++; $display("FAIL addu_wb got state=%0h reg_W=%0h reg_dst=%0h wb_src=%0h pc_W=%0h exp 4 1 0 0 1", state, reg_W, reg_dst, wb_src, pc_W); end
    tick();
    checks++; if (state !== 3'd0 || retired !== 32'd1) begin errors++; $display("FAIL addu_done got state=%0h retired=%0h exp 0 1", state, retired); end
  endtask

  task automatic test_lw();
    op = 6'h23; dmem_ready = 1'b0;
    tick(); tick();
    checks++; if (aluc !== 4'b0000 || ext !== 5'b01000 || alu_b_imm !== 1'b1)
      begin errors++; $display("FAIL lw_exec got aluc=%0h ext=%0h b_imm=%0h exp 0 8 1", aluc, ext, alu_b_imm); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) begin dmem_ready = 1'b1; #1; end
      checks++; if (state !== 3'd3 || dmem_R !== 1'b1 || reg_W !== 1'b0)
        begin errors++; $display("FAIL lw_mem%0d got state=%0h dmem_R=%0h reg_W=%0h exp 3 1 0", i, state, dmem_R, reg_W); end
    end
    tick();
    checks++; if (state !== 3'd4 || wb_src !== 2'b01 || reg_dst !== 2'b01 || reg_W !== 1'b1 || dmem_R !== 1'b0)
      begin errors++; $display("FAIL lw_wb got state=%0h wb_src=%0h reg_dst=%0h reg_W=%0h dmem_R=%0h exp 4 1 1 1 0", state, wb_src, reg_dst, reg_W, dmem_R); end
    tick();
    checks++; if (state !== 3'd0 || retired !== 32'd2) begin errors++; $display("FAIL lw_done got state=%0h retired=%0h exp 0 2", state, retired); end
  endtask

  task automatic test_branch();
    op = 6'h04; Z = 1'b1;
    tick(); tick();
    checks++; if (pc_src !== 2'b01 || pc_W !== 1'b1 || reg_W !== 1'b0 || aluc !== 4'b0001 || ext !== 5'b10000)
      begin errors++; $display("FAIL beq_taken got pc_src=%0h pc_W=%0h reg_W=%0h aluc=%0h ext=%0h exp 1 1 0 1 10", pc_src, pc_W, reg_W, aluc, ext); end
    tick();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL beq_taken_next got %0h exp 0", state); end
    Z = 1'b0;
    tick(); tick();
    checks++; if (pc_src !== 2'b00 || pc_W !== 1'b1 || reg_W !== 1'b0)
      begin errors++; $display("FAIL beq_nt got pc_src=%0h pc_W=%0h reg_W=%0h exp 0 1 0", pc_src, pc_W, reg_W); end
    tick();
    op = 6'h05;
    tick(); tick();
    checks++; if (pc_src !== 2'b01 || pc_W !== 1'b1) begin errors++; $display("FAIL bne_taken got pc_src=%0h pc_W=%0h exp 1 1", pc_src, pc_W); end
    tick();
    checks++; if (state !== 3'd0 || retired !== 32'd5) begin errors++; $display("FAIL branch_done got state=%0h retired=%0h exp 0 5", state, retired); end
  endtask

  task automatic test_jal();
    op = 6'h03;
    tick(); tick();
    checks++; if (state !== 3'd2 || pc_src !== 2'b10 || pc_W !== 1'b1 || reg_W !== 1'b1 || reg_dst !== 2'b10 || wb_src !== 2'b10)
      begin errors++; $display("FAIL jal_exec got state=%0h pc_src=%0h pc_W=%0h reg_W=%0h reg_dst=%0h wb_src=%0h exp 2 2 1 1 2 2", state, pc_src, pc_W, reg_W, reg_dst, wb_src); end
    tick();
    checks++; if (state !== 3'd0 || retired !== 32'd6) begin errors++; $display("FAIL jal_done got state=%0h retired=%0h exp 0 6", state, retired); end
  endtask

  task automatic test_illegal();
    op = 6'h3F;
    tick();
    checks++; if (state !== 3'd1 || illegal !== 1'b1 || pc_W !== 1'b1 || pc_src !== 2'b00)
      begin errors++; $display("FAIL ill_op got state=%0h illegal=%0h pc_W=%0h pc_src=%0h exp 1 1 1 0", state, illegal, pc_W, pc_src); end
    tick();
    checks++; if (state !== 3'd0 || illegal !== 1'b0 || retired !== 32'd6)
      begin errors++; $display("FAIL ill_op_after got state=%0h illegal=%0h retired=%0h exp 0 0 6", state, illegal, retired); end
    op = 6'h00; funct = 6'h01;
    tick();
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill_funct got %0h exp 1", illegal); end
    tick();
    checks++; if (state !== 3'd0 || retired !== 32'd6) begin errors++; $display("FAIL ill_funct_after got state=%0h retired=%0h exp 0 6", state, retired); end
  endtask

  task automatic test_misc();
    op = 6'h00; funct = 6'h00;
    tick(); tick();
    checks++; if (aluc !== 4'b1110 || ext !== 5'b00010 || alu_a_sa !== 1'b1 || alu_b_imm !== 1'b0)
      begin errors++; $display("FAIL sll_exec got aluc=%0h ext=%0h a_sa=%0h b_imm=%0h exp e 2 1 0", aluc, ext, alu_a_sa, alu_b_imm); end
    tick();
    checks++; if (state !== 3'd4 || reg_dst !== 2'b00) begin errors++; $display("FAIL sll_wb got state=%0h reg_dst=%0h exp 4 0", state, reg_dst); end
    tick();
    op = 6'h0A;
    tick(); tick();
    checks++; if (aluc !== 4'b1011 || ext !== 5'b01001 || alu_b_imm !== 1'b1 || alu_a_sa !== 1'b0)
      begin errors++; $display("FAIL slti_exec got aluc=%0h ext=%0h b_imm=%0h a_sa=%0h exp b 9 1 0", aluc, ext, alu_b_imm, alu_a_sa); end
    tick();
    checks++; if (reg_dst !== 2'b01 || reg_W !== 1'b1) begin errors++; $display("FAIL slti_wb got reg_dst=%0h reg_W=%0h exp 1 1", reg_dst, reg_W); end
    tick();
    op = 6'h2B;
    tick(); tick(); tick();
    checks++; if (state !== 3'd3 || dmem_W !== 1'b1 || dmem_R !== 1'b0 || pc_W !== 1'b1 || reg_W !== 1'b0)
      begin errors++; $display("FAIL sw_mem got state=%0h dmem_W=%0h dmem_R=%0h pc_W=%0h reg_W=%0h exp 3 1 0 1 0", state, dmem_W, dmem_R, pc_W, reg_W); end
    tick();
    op = 6'h00; funct = 6'h08;
    tick(); tick();
    checks++; if (pc_src !== 2'b11 || pc_W !== 1'b1 || reg_W !== 1'b0)
      begin errors++; $display("FAIL jr_exec got pc_src=%0h pc_W=%0h reg_W=%0h exp 3 1 0", pc_src, pc_W, reg_W); end
    tick();
    checks++; if (state !== 3'd0 || retired !== 32'd10) begin errors++; $display("FAIL misc_done got state=%0h retired=%0h exp 0 a", state, retired); end
  endtask

  task automatic test_abort();
    op = 6'h00; funct = 6'h21;
    tick(); tick(); tick();
    checks++; if (state !== 3'd4 || reg_W !== 1'b1) begin errors++; $display("FAIL abort_pre got state=%0h reg_W=%0h exp 4 1", state, reg_W); end
    rst = 1'b1;
    #1;
    checks++; if (state !== 3'd0 || reg_W !== 1'b0 || pc_W !== 1'b0 || imem_req !== 1'b0)
      begin errors++; $display("FAIL abort got state=%0h reg_W=%0h pc_W=%0h imem_req=%0h exp 0 0 0 0", state, reg_W, pc_W, imem_req); end
    checks++; if (retired !== 32'd0) begin errors++; $display("FAIL abort_retired got %0h exp 0", retired); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_timeout();
    imem_ready = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      checks++; if (state !== 3'd0 || imem_req !== 1'b1 || fault !== 1'b0)
        begin errors++; $display("FAIL to_wait%0d got state=%0h imem_req=%0h fault=%0h exp 0 1 0", i, state, imem_req, fault); end
      tick();
    end
    checks++; if (state !== 3'd7 || fault !== 1'b1 || imem_req !== 1'b0)
      begin errors++; $display("FAIL to_fault got state=%0h fault=%0h imem_req=%0h exp 7 1 0", state, fault, imem_req); end
    imem_ready = 1'b1;
    tick(); tick();
    checks++; if (state !== 3'd7 || fault !== 1'b1 || ir_W !== 1'b0)
      begin errors++; $display("FAIL to_sticky got state=%0h fault=%0h ir_W=%0h exp 7 1 0", state, fault, ir_W); end
    rst = 1'b1;
    #1;
    checks++; if (state !== 3'd0 || fault !== 1'b0) begin errors++; $display("FAIL to_clear got state=%0h fault=%0h exp 0 0", state, fault); end
    tick();
    rst = 1'b0; imem_ready = 1'b0;
    #1;
    for (int i = 0; i < 15; i++) tick();
    imem_ready = 1'b1;
    #1;
    checks++; if (state !== 3'd0 || ir_W !== 1'b1) begin errors++; $display("FAIL to_late_ready got state=%0h ir_W=%0h exp 0 1", state, ir_W); end
    tick();
    checks++; if (state !== 3'd1 || fault !== 1'b0) begin errors++; $display("FAIL to_no_fault got state=%0h fault=%0h exp 1 0", state, fault); end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw();
    test_branch();
    test_jal();
    test_illegal();
    test_misc();
    test_abort();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Parametrised multi-cycle successor to the single-cycle MIPS-31 controller.
- Decodes op/funct from the instruction register once per instruction and sequences FETCH, DECODE, EXEC, MEM and WB through an FSM.
- Handshakes with instruction and data memories that may stall, and detects illegal opcodes and memory timeouts.
- Drives the same datapath control set (mux selects, aluc, ext, memory and regfile enables) plus a retired-instruction counter.

Parameters:
- TIMEOUT, 16: maximum wait cycles for imem_ready/dmem_ready; 0 disables the timeout.
- RET_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- op  in  6  IR[31:26]; valid from DECODE until the next FETCH.
- funct  in  6  IR[5:0].
- Z  in  1  ALU zero flag; valid in EXEC.
- imem_ready  in  1  instruction word valid this cycle.
- dmem_ready  in  1  data access complete this cycle.
- imem_req  out  1  instruction fetch request.
- ir_W  out  1  IR load strobe.
- pc_W  out  1  PC write enable.
- pc_src  out  2  next-PC select: 00 = PC+4, 01 = branch target (PC+4+S_Ext18), 10 = jump concatenation, 11 = rs.
- dmem_R  out  1  data memory read.
- dmem_W  out  1  data memory write.
- reg_W  out  1  regfile write enable.
- reg_dst  out  2  destination select: 00 = rd, 01 = rt, 10 = $31.
- wb_src  out  2  write-back source: 00 = ALU, 01 = DMEM, 10 = PC+4.
- alu_a_sa  out  1  ALU A takes Ext5(shamt): sll, srl, sra.
- alu_b_imm  out  1  ALU B takes the extended immediate.
- ext  out  5  one-hot extender select: [0] Ext1, [1] Ext5, [2] Ext16, [3] S_Ext16, [4] S_Ext18.
- aluc  out  4  ALU operation.
- state  out  3  current FSM state, for debug.
- illegal  out  1  one-cycle pulse on an undecodable instruction.
- fault  out  1  sticky memory-timeout flag.
- retired  out  RET_W  count of retired legal instructions.

Behaviour:
- Reset (async, rst=1):
  - state = FETCH (000).
  - fault = 0, retired = 0, wait counter = 0.
  - All outputs are forced to 0 while rst=1, including imem_req.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=7.
- Instruction class is registered in DECODE. Control outputs are combinational from state and the registered class; any output not listed as asserted in a state is 0.
- FETCH:
  - imem_req=1.
  - On imem_ready: ir_W=1 in the same cycle, then go to DECODE.
- DECODE:
  - Classify the 31 instructions: R-ALU, shift, I-ALU, lui, lw, sw, beq, bne, j, jal, jr.
  - Undefined op/funct: illegal=1, pc_W=1, pc_src=00, go to FETCH. The instruction is skipped and retired is not incremented.
  - Otherwise go to EXEC.
- EXEC:
  - aluc, ext, alu_a_sa and alu_b_imm are driven per instruction.
  - aluc codes:
    - addu/lw/sw = 0000, subu/beq/bne = 0001, add/addi = 0010, sub = 0011.
    - and/andi = 0100, or/ori = 0101, xor/xori = 0110, nor = 0111.
    - lui = 1000, sltu/sltiu = 1010, slt/slti = 1011.
    - sra/srav = 1100, srl/srlv = 1101, sll/sllv = 1110.
  - ext codes:
    - Ext1: slt, sltu, slti, sltiu.
    - Ext5: sll, srl, sra.
    - Ext16: andi, ori, xori, lui.
    - S_Ext16: addi, addiu, lw, sw, slti, sltiu.
    - S_Ext18: beq, bne.
  - Next state by class:
    - ALU classes: go to WB.
    - lw/sw: go to MEM.
    - beq/bne: pc_W=1; pc_src=01 if (beq&Z)|(bne&~Z), else 00; go to FETCH.
    - j: pc_W=1, pc_src=10, go to FETCH.
    - jal: as j, plus reg_W=1, reg_dst=10, wb_src=10; go to FETCH.
    - jr: pc_W=1, pc_src=11, go to FETCH.
- MEM:
  - lw: dmem_R=1 until dmem_ready, then go to WB.
  - sw: dmem_W=1 until dmem_ready; on ready pc_W=1, pc_src=00, go to FETCH.
- WB:
  - reg_W=1, pc_W=1, pc_src=00.
  - reg_dst: rd for R-type, rt for I-type/lw.
  - wb_src: 01 for lw, else 00.
  - Go to FETCH.
- retired increments by 1, wrapping, on every cycle with pc_W=1 except the illegal skip.
- Zero-wait latency: ALU and shift = 4 cycles, lw = 5, sw = 4, branch/jump = 3.
- Timeout:
  - The wait counter increments each FETCH/MEM cycle without the relevant ready signal and clears on any state change.
  - If TIMEOUT>0 and the counter equals TIMEOUT-1 with ready still low, the next state is FAULT.
  - Ready arriving on that same cycle wins: normal transition, no fault.
- FAULT: every enable is 0 and fault=1; the block stays in FAULT until rst.
- rst mid-instruction aborts immediately. No partial reg_W/dmem_W is issued after rst asserts.

Test Plan:
- Zero-wait addu (op=0, funct=0x21): states 0,1,2,4,0; aluc=0000, reg_dst=00, reg_W=1 only in WB; retired 0→1.
- lw with dmem_ready delayed 3 cycles: dmem_R high for 4 MEM cycles, then WB with wb_src=01, reg_dst=01; total 8 cycles.
- beq with Z=1 versus Z=0: pc_src=01 versus 00 in EXEC, pc_W=1, reg_W=0; 3 cycles each.
- jal: in EXEC pc_src=10, reg_W=1, reg_dst=10, wb_src=10; next state FETCH.
- op=0x3F: illegal pulses 1 cycle in DECODE, pc_W=1, retired unchanged.
- TIMEOUT=16, imem_ready held low: FAULT entered after 16 FETCH cycles, fault=1 and sticky; rst clears to FETCH. Repeat with ready on cycle 16: no fault.
